// File: rtl/vc_phase_sequencer_if.sv
// Control and status bundle between a phase-sequencer master and the sequencer.
// Durations are packed per phase: phase k lives in dur_flat[k*CNT_W +: CNT_W].
interface vc_phase_sequencer_if #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = 4
);
    logic                        start;
    logic                        stop;
    logic                        pause;
    logic                        oneshot;
    logic [NUM_PHASES*CNT_W-1:0] dur_flat;
    logic [NUM_PHASES-1:0]       phase_en;
    logic [IDX_W-1:0]            phase_idx;
    logic [CNT_W-1:0]            phase_cnt;
    logic                        phase_done;
    logic                        wrap;
    logic                        busy;

    modport master (
        output start, stop, pause, oneshot, dur_flat,
        input  phase_en, phase_idx, phase_cnt, phase_done, wrap, busy
    );

    modport slave (
        input  start, stop, pause, oneshot, dur_flat,
        output phase_en, phase_idx, phase_cnt, phase_done, wrap, busy
    );
endinterface

// File: rtl/vc_phase_sequencer.sv
// N-phase sequencer with per-phase programmable durations, loop/one-shot modes,
// pause and stop; drives one-hot phase enables to the delay-line/crossfade blocks.
module vc_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    vc_phase_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;

    state_t                r_state;
    logic [NUM_PHASES-1:0] r_en;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_dur;
    logic                  r_done;
    logic                  r_wrap;
    logic                  r_busy;

    logic [CNT_W-1:0]      w_dur [2**IDX_W];
    logic [IDX_W-1:0]      w_nidx;
    logic                  w_last;
    logic                  w_final;

    // Table padded to the full index range so any phase_idx selects a legal entry;
    // a zero duration is promoted to one cycle here.
    for (genvar k = 0; k < 2**IDX_W; k++) begin : g_dur
        if (k < NUM_PHASES) begin : g_real
            assign w_dur[k] = (bus.dur_flat[k*CNT_W +: CNT_W] == '0)
                              ? CNT_W'(1) : bus.dur_flat[k*CNT_W +: CNT_W];
        end else begin : g_pad
            assign w_dur[k] = CNT_W'(1);
        end
    end

    assign w_nidx  = r_idx + IDX_W'(1);
    assign w_last  = (r_idx == IDX_W'(NUM_PHASES - 1));
    assign w_final = (r_cnt == r_dur - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_en    <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_dur   <= CNT_W'(1);
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.stop) begin
                r_state <= S_IDLE;
                r_en    <= '0;
                r_idx   <= '0;
                r_cnt   <= '0;
                r_dur   <= CNT_W'(1);
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start && !bus.pause) begin
                            r_state <= S_RUN;
                            r_en    <= NUM_PHASES'(1);
                            r_idx   <= '0;
                            r_cnt   <= '0;
                            r_dur   <= w_dur[0];
                            r_busy  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // Pause is checked first so a pause on a final cycle defers the hand-off.
                        if (bus.pause) begin
                            r_state <= S_PAUSED;
                        end else if (w_final) begin
                            r_done <= 1'b1;
                            r_cnt  <= '0;
                            if (!w_last) begin
                                r_idx <= w_nidx;
                                r_en  <= r_en << 1;
                                r_dur <= w_dur[w_nidx];
                            end else begin
                                r_wrap <= 1'b1;
                                r_idx  <= '0;
                                if (bus.oneshot) begin
                                    r_state <= S_IDLE;
                                    r_en    <= '0;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_en  <= NUM_PHASES'(1);
                                    r_dur <= w_dur[0];
                                end
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_PAUSED: begin
                        if (!bus.pause) begin
                            r_state <= S_RUN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.phase_en   = r_en;
    assign bus.phase_idx  = r_idx;
    assign bus.phase_cnt  = r_cnt;
    assign bus.phase_done = r_done;
    assign bus.wrap       = r_wrap;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_vc_phase_sequencer.sv
// Self-checking bench: directed scenarios plus random control traffic, all outputs
// compared every cycle against a phase-level reference model.
module tb_vc_phase_sequencer;
    localparam int N  = 4;
    localparam int CW = 16;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vc_phase_sequencer_if #(.NUM_PHASES(N), .CNT_W(CW), .IDX_W(IW)) bus ();

    vc_phase_sequencer #(.NUM_PHASES(N), .CNT_W(CW), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int d_cur [N];
    bit m_busy, m_paused, m_done, m_wrap;
    int m_idx, m_cnt, m_dur;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic apply_dur();
        for (int k = 0; k < N; k++) bus.dur_flat[k*CW +: CW] = CW'(d_cur[k]);
    endtask

    task automatic model_reset();
        m_busy = 0; m_paused = 0; m_done = 0; m_wrap = 0;
        m_idx = 0; m_cnt = 0; m_dur = 1;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        m_done = 0;
        m_wrap = 0;
        if (bus.stop) begin
            model_reset();
        end else if (!m_busy) begin
            if (bus.start && !bus.pause) begin
                m_busy = 1; m_paused = 0; m_idx = 0; m_cnt = 0; m_dur = eff(d_cur[0]);
            end
        end else if (m_paused) begin
            if (!bus.pause) m_paused = 0;
        end else if (bus.pause) begin
            m_paused = 1;
        end else if (m_cnt + 1 == m_dur) begin
            m_done = 1;
            m_cnt  = 0;
            if (m_idx == N - 1) begin
                m_wrap = 1;
                m_idx  = 0;
                if (bus.oneshot) m_busy = 0;
                else             m_dur  = eff(d_cur[0]);
            end else begin
                m_idx = m_idx + 1;
                m_dur = eff(d_cur[m_idx]);
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_outputs();
        check("phase_en",   bus.phase_en,   m_busy ? (64'd1 << m_idx) : 64'd0);
        check("phase_idx",  bus.phase_idx,  m_idx);
        check("phase_cnt",  bus.phase_cnt,  m_cnt);
        check("phase_done", bus.phase_done, m_done);
        check("wrap",       bus.wrap,       m_wrap);
        check("busy",       bus.busy,       m_busy);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    task automatic set_plan_durs();
        d_cur[0] = 3; d_cur[1] = 2; d_cur[2] = 5; d_cur[3] = 1;
        apply_dur();
    endtask

    initial begin
        int q[$];
        int n;
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.oneshot = 0;
        for (int k = 0; k < N; k++) d_cur[k] = 1;
        apply_dur();
        rst = 1'b1;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Looping four-phase run with the reference durations.
        set_plan_durs();
        bus.oneshot = 0;
        pulse_start();
        for (int j = 1; j <= 22; j++) begin
            step();
            if (bus.phase_done) q.push_back(j);
        end
        check("done_count", q.size(), 8);
        if (q.size() >= 4) begin
            check("done_pos0", q[0], 3);
            check("done_pos1", q[1], 5);
            check("done_pos2", q[2], 10);
            check("done_pos3", q[3], 11);
        end
        pulse_stop();

        // One-shot: sequence ends after 11 running cycles, then restarts on demand.
        bus.oneshot = 1;
        pulse_start();
        n = 0;
        while (bus.busy && n < 40) begin
            step();
            n++;
        end
        check("oneshot_len", n, 11);
        pulse_start();
        check("restart_en", bus.phase_en, 1);
        for (int j = 0; j < 4; j++) step();
        pulse_stop();

        // Zero duration on phase 1 collapses to a single cycle.
        d_cur[1] = 0;
        apply_dur();
        pulse_start();
        for (int j = 1; j <= 12; j++) begin
            step();
            if (j == 3 || j == 4) check("zero_dur_done", bus.phase_done, 1);
        end
        pulse_stop();

        // Pause for 4 cycles at phase 2, count 2.
        set_plan_durs();
        bus.oneshot = 0;
        pulse_start();
        for (int j = 0; j < 7; j++) step();
        bus.pause = 1;
        for (int j = 0; j < 4; j++) begin
            step();
            check("pause_cnt", bus.phase_cnt, 2);
            check("pause_en", bus.phase_en, 4'b0100);
        end
        bus.pause = 0;
        for (int j = 0; j < 10; j++) step();
        pulse_stop();

        // Mid-phase duration change, then stop on the final cycle of phase 3.
        pulse_start();
        for (int j = 0; j < 3; j++) step();
        d_cur[1] = 9;
        apply_dur();
        for (int j = 0; j < 7; j++) step();
        check("pre_stop_idx", bus.phase_idx, 3);
        pulse_stop();
        check("stop_no_wrap", bus.wrap, 0);
        bus.start = 1; bus.stop = 1;
        step();
        bus.start = 0; bus.stop = 0;
        check("start_stop_idle", bus.busy, 0);
        set_plan_durs();

        // Asynchronous reset mid-phase 1.
        pulse_start();
        for (int j = 0; j < 4; j++) step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) step();

        // Random control traffic.
        for (int i = 0; i < 1500; i++) begin
            bus.start = ($urandom_range(5) == 0);
            bus.stop  = ($urandom_range(39) == 0);
            if (!m_busy)                      bus.pause = 0;
            else if ($urandom_range(5) == 0)  bus.pause = ~bus.pause;
            if ($urandom_range(19) == 0) bus.oneshot = ~bus.oneshot;
            if ($urandom_range(7) == 0) begin
                d_cur[$urandom_range(N - 1)] = $urandom_range(6);
                apply_dur();
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
